// File: rtl/kernel_launcher_if.sv
// Host command, preload-memory and GPU-control bundle for kernel_launcher.
// slave: seen from the launcher; master: seen from the host/memory/GPU side.
interface kernel_launcher_if #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [ADDR_BITS-1:0] cmd_addr;
    logic [DATA_BITS-1:0] cmd_data;

    logic                 mem_write_valid;
    logic [ADDR_BITS-1:0] mem_write_address;
    logic [DATA_BITS-1:0] mem_write_data;
    logic                 mem_write_ready;

    logic                 gpu_start;
    logic [7:0]           gpu_thread_count;
    logic                 gpu_done;

    logic                 busy;
    logic [7:0]           kernel_count;
    logic                 err_illegal;
    logic                 err_timeout;

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data,
        input  mem_write_ready, gpu_done,
        output cmd_ready,
        output mem_write_valid, mem_write_address, mem_write_data,
        output gpu_start, gpu_thread_count,
        output busy, kernel_count, err_illegal, err_timeout
    );

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data,
        output mem_write_ready, gpu_done,
        input  cmd_ready,
        input  mem_write_valid, mem_write_address, mem_write_data,
        input  gpu_start, gpu_thread_count,
        input  busy, kernel_count, err_illegal, err_timeout
    );
endinterface

// File: rtl/kernel_launcher.sv
// In-order host command sequencer (memory preload writes, kernel launches) ahead of miniGPU.
// Optional RUN watchdog enabled by defining WATCHDOG_EN.
//
// state  | meaning
// IDLE   | pop one queued command per cycle and dispatch it
// MEMWR  | hold a preload write until memory accepts it
// LAUNCH | one-cycle gpu_start pulse
// RUN    | wait for gpu_done (or watchdog expiry)
module kernel_launcher #(
    parameter int ADDR_BITS  = 8,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int WDT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             reset,
    kernel_launcher_if.slave kl_if
);
    localparam int PTR_BITS = $clog2(FIFO_DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;

    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_MEMWR  = 2'b01;
    localparam logic [1:0] OP_LAUNCH = 2'b10;
    localparam logic [1:0] OP_ILL    = 2'b11;

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("kernel_launcher: FIFO_DEPTH must be a power of two >= 2");
    end
    if (WDT_CYCLES < 2) begin : g_bad_wdt
        $error("kernel_launcher: WDT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MEMWR  = 2'd1,
        S_LAUNCH = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [1:0]           op_mem   [FIFO_DEPTH];
    logic [ADDR_BITS-1:0] addr_mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0] data_mem [FIFO_DEPTH];

    logic [PTR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0]  count_q, count_d;
    logic                 ready_q, ready_d;
    logic [ADDR_BITS-1:0] cur_addr_q, cur_addr_d;
    logic [DATA_BITS-1:0] cur_data_q, cur_data_d;
    logic [7:0]           thread_count_q, thread_count_d;
    logic [7:0]           kernel_count_q, kernel_count_d;
    logic                 err_illegal_q, err_illegal_d;

    logic                 push;
    logic                 pop;
    logic                 fifo_empty;
    logic                 load_launch;
    logic                 set_illegal;
    logic                 kernel_done;
    logic                 wdt_expired;
    logic [1:0]           head_op;
    logic [ADDR_BITS-1:0] head_addr;
    logic [DATA_BITS-1:0] head_data;

    // cmd_ready is registered so it reads 0 during reset and never sees a same-cycle pop.
    assign push       = kl_if.cmd_valid && ready_q;
    assign fifo_empty = (count_q == '0);
    assign head_op    = op_mem[rd_ptr_q];
    assign head_addr  = addr_mem[rd_ptr_q];
    assign head_data  = data_mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr_q]   <= kl_if.cmd_op;
            addr_mem[wr_ptr_q] <= kl_if.cmd_addr;
            data_mem[wr_ptr_q] <= kl_if.cmd_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        load_launch = 1'b0;
        set_illegal = 1'b0;
        kernel_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    case (head_op)
                        OP_MEMWR: state_d = S_MEMWR;
                        OP_LAUNCH: begin
                            if (head_data != '0) begin
                                load_launch = 1'b1;
                                state_d     = S_LAUNCH;
                            end else begin
                                set_illegal = 1'b1;
                            end
                        end
                        OP_ILL: set_illegal = 1'b1;
                        OP_NOP: ;
                        default: ;
                    endcase
                end
            end
            S_MEMWR: begin
                if (kl_if.mem_write_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: state_d = S_RUN;
            S_RUN: begin
                // A completion on the expiry cycle wins over the timeout.
                if (kl_if.gpu_done) begin
                    kernel_done = 1'b1;
                    state_d     = S_IDLE;
                end else if (wdt_expired) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_BITS'(1);
            2'b01:   count_d = count_q - CNT_BITS'(1);
            default: count_d = count_q;
        endcase
        ready_d        = (count_d != CNT_BITS'(FIFO_DEPTH));
        cur_addr_d     = pop ? head_addr : cur_addr_q;
        cur_data_d     = pop ? head_data : cur_data_q;
        thread_count_d = load_launch ? 8'(head_data) : thread_count_q;
        kernel_count_d = kernel_done ? kernel_count_q + 8'd1 : kernel_count_q;
        err_illegal_d  = err_illegal_q | set_illegal;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            ready_q        <= 1'b0;
            cur_addr_q     <= '0;
            cur_data_q     <= '0;
            thread_count_q <= '0;
            kernel_count_q <= '0;
            err_illegal_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            ready_q        <= ready_d;
            cur_addr_q     <= cur_addr_d;
            cur_data_q     <= cur_data_d;
            thread_count_q <= thread_count_d;
            kernel_count_q <= kernel_count_d;
            err_illegal_q  <= err_illegal_d;
        end
    end

`ifdef WATCHDOG_EN
    localparam int WDT_BITS = (WDT_CYCLES > 2) ? $clog2(WDT_CYCLES) : 1;

    logic [WDT_BITS-1:0] wdt_q, wdt_d;
    logic                err_timeout_q, err_timeout_d;

    assign wdt_expired = (state_q == S_RUN) && (wdt_q == WDT_BITS'(WDT_CYCLES - 1));

    always_comb begin
        wdt_d         = wdt_q;
        err_timeout_d = err_timeout_q;
        if (state_q == S_LAUNCH) begin
            wdt_d = '0;
        end else if (state_q == S_RUN) begin
            wdt_d = wdt_q + WDT_BITS'(1);
        end
        if (wdt_expired && !kl_if.gpu_done) begin
            err_timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdt_q         <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            wdt_q         <= wdt_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign kl_if.err_timeout = err_timeout_q;
`else
    assign wdt_expired       = 1'b0;
    assign kl_if.err_timeout = 1'b0;
`endif

    assign kl_if.cmd_ready         = ready_q;
    assign kl_if.mem_write_valid   = (state_q == S_MEMWR);
    assign kl_if.mem_write_address = cur_addr_q;
    assign kl_if.mem_write_data    = cur_data_q;
    assign kl_if.gpu_start         = (state_q == S_LAUNCH);
    assign kl_if.gpu_thread_count  = thread_count_q;
    assign kl_if.busy              = (state_q != S_IDLE) || !fifo_empty;
    assign kl_if.kernel_count      = kernel_count_q;
    assign kl_if.err_illegal       = err_illegal_q;
endmodule

// File: tb/tb_kernel_launcher.sv
// Directed bench for kernel_launcher: a per-cycle vector table plus hand-written
// multi-cycle sequences (full FIFO, ordering behind RUN, reset abort, watchdog).
module tb_kernel_launcher;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    kernel_launcher_if #(.ADDR_BITS(8), .DATA_BITS(8)) kif ();

    kernel_launcher #(
        .ADDR_BITS(8), .DATA_BITS(8), .FIFO_DEPTH(4), .WDT_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .kl_if(kif)
    );

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic       v;
        logic [1:0] op;
        logic [7:0] addr;
        logic [7:0] data;
        logic       mrdy;
        logic       done;
        logic       e_rdy;
        logic       e_mv;
        logic [7:0] e_ma;
        logic [7:0] e_md;
        logic       e_st;
        logic [7:0] e_tc;
        logic       e_busy;
        logic [7:0] e_kc;
        logic       e_ill;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
        kif.cmd_valid = v;
        kif.cmd_op    = op;
        kif.cmd_addr  = a;
        kif.cmd_data  = d;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   idx;
        int   cnt_st;
        int   cnt_mv;
        int   busy_bad;
        logic found;

        vecs[0]  = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 2'd1, 8'h10, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h10, 8'hA5, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4]  = '{1'b1, 2'd3, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0};
        vecs[5]  = '{1'b1, 2'd2, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[6]  = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1};
        vecs[7]  = '{1'b1, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[8]  = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1};
        vecs[9]  = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1};
        vecs[10] = '{1'b1, 2'd2, 8'h00, 8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[11] = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h03, 1'b1, 8'h00, 1'b1};
        vecs[12] = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h03, 1'b1, 8'h00, 1'b1};
        vecs[13] = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h03, 1'b0, 8'h01, 1'b1};
        vecs[14] = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h03, 1'b0, 8'h01, 1'b1};
        vecs[15] = '{1'b1, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h03, 1'b1, 8'h01, 1'b1};
        vecs[16] = '{1'b1, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h03, 1'b1, 8'h01, 1'b1};
        vecs[17] = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h03, 1'b0, 8'h01, 1'b1};

        rst_n = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 8'h00);
        kif.mem_write_ready = 1'b1;
        kif.gpu_done        = 1'b0;
        tick();
        tick();
        check("reset.cmd_ready",   kif.cmd_ready, 0);
        check("reset.mem_valid",   kif.mem_write_valid, 0);
        check("reset.gpu_start",   kif.gpu_start, 0);
        check("reset.thread_cnt",  kif.gpu_thread_count, 0);
        check("reset.busy",        kif.busy, 0);
        check("reset.kernel_cnt",  kif.kernel_count, 0);
        check("reset.err_illegal", kif.err_illegal, 0);
        check("reset.err_timeout", kif.err_timeout, 0);
        rst_n = 1'b1;

        // Per-cycle table: inputs held for one edge, outputs checked just after it.
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].v, vecs[i].op, vecs[i].addr, vecs[i].data);
            kif.mem_write_ready = vecs[i].mrdy;
            kif.gpu_done        = vecs[i].done;
            tick();
            check($sformatf("vec%0d.cmd_ready", i),  kif.cmd_ready, vecs[i].e_rdy);
            check($sformatf("vec%0d.mem_valid", i),  kif.mem_write_valid, vecs[i].e_mv);
            if (vecs[i].e_mv) begin
                check($sformatf("vec%0d.mem_addr", i), kif.mem_write_address, vecs[i].e_ma);
                check($sformatf("vec%0d.mem_data", i), kif.mem_write_data, vecs[i].e_md);
            end
            check($sformatf("vec%0d.gpu_start", i),  kif.gpu_start, vecs[i].e_st);
            check($sformatf("vec%0d.thread_cnt", i), kif.gpu_thread_count, vecs[i].e_tc);
            check($sformatf("vec%0d.busy", i),       kif.busy, vecs[i].e_busy);
            check($sformatf("vec%0d.kernel_cnt", i), kif.kernel_count, vecs[i].e_kc);
            check($sformatf("vec%0d.err_illegal", i), kif.err_illegal, vecs[i].e_ill);
        end
        drive(1'b0, 2'd0, 8'h00, 8'h00);
        kif.gpu_done = 1'b0;

        // Launch 8 threads; gpu_done arrives 20 cycles after the start pulse.
        drive(1'b1, 2'd2, 8'h00, 8'h08);
        tick();
        drive(1'b0, 2'd0, 8'h00, 8'h00);
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            tick();
            found = kif.gpu_start;
        end
        check("seq1.start_seen", found, 1);
        check("seq1.thread_cnt", kif.gpu_thread_count, 8'h08);
        cnt_st   = 0;
        busy_bad = 0;
        for (int i = 0; i < 20; i++) begin
            cnt_st += int'(kif.gpu_start);
            if (!kif.busy) busy_bad++;
            tick();
        end
        check("seq1.start_pulses", cnt_st, 1);
        check("seq1.busy_in_run", busy_bad, 0);
        kif.gpu_done = 1'b1;
        tick();
        kif.gpu_done = 1'b0;
        check("seq1.kernel_cnt", kif.kernel_count, 8'd2);
        check("seq1.busy_after", kif.busy, 0);
        check("seq1.thread_hold", kif.gpu_thread_count, 8'h08);

        // Fill the FIFO behind a stalled write, then drain in order.
        kif.mem_write_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("seq2.ready_before_push%0d", i), kif.cmd_ready, 1);
            drive(1'b1, 2'd1, 8'(8'h30 + i), 8'(8'h40 + i));
            tick();
        end
        check("seq2.ready_full", kif.cmd_ready, 0);
        drive(1'b1, 2'd1, 8'h3F, 8'h4F);
        tick();
        drive(1'b0, 2'd0, 8'h00, 8'h00);
        check("seq2.ready_still_full", kif.cmd_ready, 0);
        check("seq2.stalled_valid", kif.mem_write_valid, 1);
        kif.mem_write_ready = 1'b1;
        idx = 0;
        for (int i = 0; i < 12; i++) begin
            if (kif.mem_write_valid) begin
                check($sformatf("seq2.order_addr%0d", idx), kif.mem_write_address, 8'(8'h30 + idx));
                check($sformatf("seq2.order_data%0d", idx), kif.mem_write_data, 8'(8'h40 + idx));
                idx++;
            end
            tick();
            if (i == 0) check("seq2.ready_before_pop", kif.cmd_ready, 0);
            if (i == 1) check("seq2.ready_after_pop", kif.cmd_ready, 1);
        end
        check("seq2.write_count", idx, 5);
        check("seq2.busy_end", kif.busy, 0);

        // A write queued behind a launch waits for gpu_done.
        drive(1'b1, 2'd2, 8'h00, 8'h04);
        tick();
        drive(1'b1, 2'd1, 8'h20, 8'h01);
        tick();
        drive(1'b0, 2'd0, 8'h00, 8'h00);
        cnt_st = 0;
        cnt_mv = 0;
        for (int i = 0; i < 15; i++) begin
            cnt_st += int'(kif.gpu_start);
            cnt_mv += int'(kif.mem_write_valid);
            tick();
        end
        check("seq3.start_pulses", cnt_st, 1);
        check("seq3.write_held", cnt_mv, 0);
        check("seq3.thread_cnt", kif.gpu_thread_count, 8'h04);
        kif.gpu_done = 1'b1;
        tick();
        kif.gpu_done = 1'b0;
        check("seq3.kernel_cnt", kif.kernel_count, 8'd3);
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            tick();
            found = kif.mem_write_valid;
        end
        check("seq3.write_seen", found, 1);
        check("seq3.write_addr", kif.mem_write_address, 8'h20);
        check("seq3.write_data", kif.mem_write_data, 8'h01);
        tick();
        kif.gpu_done = 1'b1;
        tick();
        kif.gpu_done = 1'b0;
        check("seq3.idle_done_ignored", kif.kernel_count, 8'd3);
        check("seq3.busy_end", kif.busy, 0);

        // Reset in the middle of a stalled write with another command queued.
        kif.mem_write_ready = 1'b0;
        drive(1'b1, 2'd1, 8'h50, 8'h55);
        tick();
        drive(1'b1, 2'd1, 8'h60, 8'h66);
        tick();
        drive(1'b0, 2'd0, 8'h00, 8'h00);
        check("seq4.in_memwr", kif.mem_write_valid, 1);
        rst_n = 1'b0;
        #1;
        check("seq4.rst_mem_valid",   kif.mem_write_valid, 0);
        check("seq4.rst_cmd_ready",   kif.cmd_ready, 0);
        check("seq4.rst_busy",        kif.busy, 0);
        check("seq4.rst_kernel_cnt",  kif.kernel_count, 0);
        check("seq4.rst_err_illegal", kif.err_illegal, 0);
        check("seq4.rst_thread_cnt",  kif.gpu_thread_count, 0);
        tick();
        rst_n = 1'b1;
        kif.mem_write_ready = 1'b1;
        cnt_mv = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            cnt_mv += int'(kif.mem_write_valid);
        end
        check("seq4.queue_lost", cnt_mv, 0);
        check("seq4.ready_back", kif.cmd_ready, 1);
        check("seq4.busy_idle", kif.busy, 0);

        // Launch with no completion: watchdog expiry, or an indefinite wait.
        drive(1'b1, 2'd2, 8'h00, 8'h08);
        tick();
        drive(1'b0, 2'd0, 8'h00, 8'h00);
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            tick();
            found = kif.gpu_start;
        end
        check("seq5.start_seen", found, 1);
`ifdef WATCHDOG_EN
        repeat (16) tick();
        check("seq5.no_timeout_yet", kif.err_timeout, 0);
        check("seq5.busy_in_run", kif.busy, 1);
        tick();
        check("seq5.err_timeout", kif.err_timeout, 1);
        check("seq5.busy_after", kif.busy, 0);
        check("seq5.kernel_cnt", kif.kernel_count, 0);
`else
        repeat (40) tick();
        check("seq5.busy_waiting", kif.busy, 1);
        check("seq5.err_timeout", kif.err_timeout, 0);
        kif.gpu_done = 1'b1;
        tick();
        kif.gpu_done = 1'b0;
        check("seq5.kernel_cnt", kif.kernel_count, 1);
        check("seq5.busy_after", kif.busy, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
